// File: rtl/fetch_pkg.sv
// Shared constants, FSM state type and opcode length decode for the fetch stage.
package fetch_pkg;

  localparam int         WINDOW_BYTES    = 160;
  localparam int         MAX_INSTR_BYTES = 16;
  localparam logic [7:0] OP_HALT         = 8'h00;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    ISSUE  = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Instruction length in bytes is the low nibble of the opcode plus one (1..16).
  function automatic logic [4:0] len_of(input logic [7:0] b0);
    return {1'b0, b0[3:0]} + 5'd1;
  endfunction

endpackage

// File: rtl/fetch_extract.sv
// Carves one instruction out of the window buffer: opcode, length and the
// zero-masked 16-byte slice starting at offset.
module fetch_extract
  import fetch_pkg::*;
#(
  parameter int WB = WINDOW_BYTES
) (
  input  logic [WB-1:0][7:0] window,
  input  logic [7:0]         offset,
  output logic [7:0]         opcode,
  output logic [127:0]       data,
  output logic [4:0]         len
);

  logic [8:0] idx;

  // Byte k of the slice is window[offset+k] when k < len and still inside the buffer.
  always_comb begin
    idx    = {1'b0, offset};
    opcode = (idx < 9'(WB)) ? window[idx[7:0]] : 8'h00;
    len    = len_of(opcode);
    data   = '0;
    for (int k = 0; k < MAX_INSTR_BYTES; k++) begin
      idx = {1'b0, offset} + 9'(k);
      if ((5'(k) < len) && (idx < 9'(WB))) begin
        data[8*k +: 8] = window[idx[7:0]];
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch control: owns the fetch PC, buffers the imemory window and issues one
// variable-length instruction per cycle to decode over valid/ready.
//
// state  | meaning
// FILL   | capture data_in into the window, offset back to 0
// ISSUE  | present the instruction at base+offset; advance or refill on accept
// HALTED | zero opcode seen; wait for a redirect
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int          WINDOW_WORDS = 20,
  parameter int          MAX_LEN      = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic [63:0]                  address,
  input  logic [WINDOW_WORDS-1:0][63:0] data_in,
  input  logic                         redirect_valid,
  input  logic [63:0]                  redirect_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [127:0]                 instr_data,
  output logic [4:0]                   instr_len,
  output logic [63:0]                  instr_pc,
  output logic                         halted
);

  localparam int         WB           = WINDOW_WORDS * 8;
  // Past this offset a maximum-length instruction might not fit in the window.
  localparam logic [8:0] REFILL_LIMIT = 9'(WB - MAX_LEN);

  state_t             state, state_next;
  logic [63:0]        base;
  logic [7:0]         offset;
  logic [WB-1:0][7:0] window;
  logic [7:0]         opcode;
  logic [4:0]         len;
  logic [127:0]       slice;
  logic [8:0]         next_off;
  logic               accept;
  logic               refill;

  fetch_extract #(.WB(WB)) u_extract (
    .window (window),
    .offset (offset),
    .opcode (opcode),
    .data   (slice),
    .len    (len)
  );

  assign next_off = {1'b0, offset} + {4'b0, len};
  assign accept   = instr_valid & instr_ready;
  assign refill   = next_off > REFILL_LIMIT;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  // Window, base and offset; a redirect overrides any same-cycle advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base   <= RESET_PC;
      offset <= '0;
      window <= '0;
    end else if (redirect_valid) begin
      base <= redirect_pc;
    end else begin
      case (state)
        FILL: begin
          window <= data_in;
          offset <= '0;
        end
        ISSUE: begin
          if (accept) begin
            if (refill) base   <= base + 64'(next_off);
            else        offset <= next_off[7:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = FILL;
    end else begin
      case (state)
        FILL:    state_next = ISSUE;
        ISSUE: begin
          if (opcode == OP_HALT)    state_next = HALTED;
          else if (accept && refill) state_next = FILL;
        end
        HALTED:  state_next = HALTED;
        default: state_next = FILL;
      endcase
    end
  end

  // Handshake and status outputs, decoded from registered state only.
  always_comb begin
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      ISSUE:   instr_valid = (opcode != OP_HALT);
      HALTED:  halted      = 1'b1;
      default: ;
    endcase
  end

  assign address    = base;
  assign instr_pc   = base + {56'b0, offset};
  assign instr_data = slice;
  assign instr_len  = len;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, hand-written
// corner sequences, then randomized traffic against a PC-level reference model.
module tb_fetch_ctrl;

  logic               clock;
  logic               reset;
  logic [63:0]        address;
  logic [19:0][63:0]  data_in;
  logic               redirect_valid;
  logic [63:0]        redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [127:0]       instr_data;
  logic [4:0]         instr_len;
  logic [63:0]        instr_pc;
  logic               halted;

  int checks = 0;
  int errors = 0;

  logic [7:0] lo_mem [0:8191];
  logic [7:0] hi_mem [0:15];

  fetch_ctrl #(.RESET_PC(64'h0), .WINDOW_WORDS(20), .MAX_LEN(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .address        (address),
    .data_in        (data_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_len      (instr_len),
    .instr_pc       (instr_pc),
    .halted         (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sparse memory: low 8 KiB plus the top 16 bytes of the address space, zero elsewhere.
  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    if (a < 64'd8192) return lo_mem[a[12:0]];
    if (a >= 64'hFFFF_FFFF_FFFF_FFF0) return hi_mem[a[3:0]];
    return 8'h00;
  endfunction

  function automatic logic [127:0] ref_data(input logic [63:0] pc, input int len);
    logic [127:0] d;
    d = '0;
    for (int k = 0; k < len; k++) d[8*k +: 8] = mem_byte(pc + 64'(k));
    return d;
  endfunction

  // imemory model; address only moves at a rising edge or reset, so refreshing on the falling edge suffices.
  always @(negedge clock) begin
    for (int i = 0; i < 160; i++) data_in[i/8][8*(i%8) +: 8] <= mem_byte(address + 64'(i));
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_instr(input string name, input logic [63:0] pc, input int len, input logic [127:0] data);
    chk({name, ".valid"}, 128'(instr_valid), 128'd1);
    chk({name, ".pc"},    128'(instr_pc),    128'(pc));
    chk({name, ".len"},   128'(instr_len),   128'(len));
    chk({name, ".data"},  instr_data,        data);
  endtask

  typedef struct {
    logic         ready;
    logic         ev;
    logic [63:0]  epc;
    logic [4:0]   elen;
    logic [127:0] edata;
    logic         eh;
  } vec_t;

  vec_t vecs [20];

  logic [63:0] m_pc, m_win;
  bit          m_bub, m_halt;
  logic [7:0]  b0;
  bit          rv, rdy;
  logic [63:0] rpc;

  initial begin
    for (int i = 0; i < 8192; i++) lo_mem[i] = 8'h00;
    for (int i = 0; i < 16; i++)   hi_mem[i] = 8'h00;
    lo_mem[0] = 8'h11; lo_mem[1] = 8'h22; lo_mem[2] = 8'h33; lo_mem[3] = 8'h44;
    lo_mem[4] = 8'h05; lo_mem[5] = 8'h66; lo_mem[6] = 8'h01; lo_mem[7] = 8'hAA;
    lo_mem[8] = 8'h00;
    for (int b = 0; b < 20; b++)
      for (int j = 0; j < 16; j++)
        lo_mem[4096 + 16*b + j] = (j == 0) ? 8'h0F : 8'(b*16 + j);
    hi_mem[8] = 8'h07;
    for (int j = 9; j < 16; j++) hi_mem[j] = 8'(8'h78 + j);

    // Directed table: reset release, backpressure, halt.
    vecs[0] = '{1'b1, 1'b0, 64'h0, 5'd0, 128'h0,        1'b0};
    vecs[1] = '{1'b1, 1'b1, 64'h0, 5'd2, 128'h2211,     1'b0};
    for (int i = 2; i <= 6; i++) vecs[i] = '{1'b0, 1'b1, 64'h2, 5'd4, 128'h66054433, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 64'h2, 5'd4, 128'h66054433, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 64'h6, 5'd2, 128'hAA01,     1'b0};
    vecs[9] = '{1'b1, 1'b0, 64'h0, 5'd0, 128'h0,        1'b0};
    for (int i = 10; i < 20; i++) vecs[i] = '{1'b1, 1'b0, 64'h0, 5'd0, 128'h0, 1'b1};

    reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset.valid",   128'(instr_valid), 128'd0);
    chk("reset.halted",  128'(halted),      128'd0);
    chk("reset.address", 128'(address),     128'd0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      chk($sformatf("vec%0d.valid", i),   128'(instr_valid), 128'(vecs[i].ev));
      chk($sformatf("vec%0d.halted", i),  128'(halted),      128'(vecs[i].eh));
      chk($sformatf("vec%0d.address", i), 128'(address),     128'd0);
      if (vecs[i].ev) chk_instr($sformatf("vec%0d", i), vecs[i].epc, int'(vecs[i].elen), vecs[i].edata);
      instr_ready = vecs[i].ready;
      step();
    end

    // Leave halt with a redirect to 0.
    redirect_valid = 1'b1; redirect_pc = 64'h0;
    step();
    redirect_valid = 1'b0;
    chk("unhalt.valid",   128'(instr_valid), 128'd0);
    chk("unhalt.halted",  128'(halted),      128'd0);
    chk("unhalt.address", 128'(address),     128'd0);
    step();
    chk_instr("unhalt.first", 64'h0, 2, 128'h2211);

    // Redirect during a stall with ready high on the same cycle.
    instr_ready = 1'b1;
    step();
    chk_instr("stall.pc2", 64'h2, 4, 128'h66054433);
    instr_ready = 1'b0;
    step(); step();
    chk_instr("stall.held", 64'h2, 4, 128'h66054433);
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h1000;
    step();
    redirect_valid = 1'b0;
    chk("redir.valid",   128'(instr_valid), 128'd0);
    chk("redir.address", 128'(address),     128'h1000);
    step();
    chk_instr("redir.first", 64'h1000, 16, ref_data(64'h1000, 16));

    // Run of 16-byte instructions up to the refill boundary.
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("run%0d.pc", k), 128'(instr_pc), 128'(64'h1000 + 64'(16*k)));
    end
    step();
    chk("refill.valid",   128'(instr_valid), 128'd0);
    chk("refill.address", 128'(address),     128'h10A0);
    step();
    chk_instr("refill.next", 64'h10A0, 16, ref_data(64'h10A0, 16));

    // Address wrap past 2^64.
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    chk("wrap.address", 128'(address), 128'(64'hFFFF_FFFF_FFFF_FFF8));
    step();
    chk_instr("wrap.top", 64'hFFFF_FFFF_FFFF_FFF8, 8, ref_data(64'hFFFF_FFFF_FFFF_FFF8, 8));
    step();
    chk_instr("wrap.zero", 64'h0, 2, 128'h2211);

    // Asynchronous reset mid-cycle while an instruction is valid.
    #3 reset = 1'b1;
    #1;
    chk("areset.valid",   128'(instr_valid), 128'd0);
    chk("areset.halted",  128'(halted),      128'd0);
    chk("areset.address", 128'(address),     128'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    chk("areset.fill", 128'(instr_valid), 128'd0);
    step();
    chk_instr("areset.first", 64'h0, 2, 128'h2211);

    // Randomized traffic against a PC-level model.
    for (int i = 0; i < 2048; i++) lo_mem[i] = 8'($urandom);
    redirect_valid = 1'b1; redirect_pc = 64'h0; instr_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    m_pc = 64'h0; m_win = 64'h0; m_bub = 1'b1; m_halt = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      b0 = mem_byte(m_pc);
      chk("rand.valid",   128'(instr_valid), 128'(!m_bub && !m_halt && b0 != 8'h00));
      chk("rand.halted",  128'(halted),      128'(m_halt));
      chk("rand.address", 128'(address),     128'(m_win));
      if (!m_bub && !m_halt && b0 != 8'h00)
        chk_instr("rand", m_pc, int'(b0[3:0]) + 1, ref_data(m_pc, int'(b0[3:0]) + 1));
      rv  = ($urandom_range(19, 0) == 0) || (m_halt && $urandom_range(3, 0) == 0);
      rpc = 64'($urandom_range(1900, 0));
      rdy = ($urandom_range(3, 0) != 0);
      redirect_valid = rv; redirect_pc = rpc; instr_ready = rdy;
      step();
      if (rv) begin
        m_bub = 1'b1; m_halt = 1'b0; m_pc = rpc; m_win = rpc;
      end else if (m_bub) begin
        m_bub = 1'b0;
      end else if (m_halt) begin
        m_halt = 1'b1;
      end else if (b0 == 8'h00) begin
        m_halt = 1'b1;
      end else if (rdy) begin
        m_pc = m_pc + 64'(b0[3:0]) + 64'd1;
        if (m_pc - m_win > 64'd144) begin
          m_bub = 1'b1;
          m_win = m_pc;
        end
      end
    end
    redirect_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch control stage placed directly upstream of `imemory`. It owns the fetch program counter and drives `imemory.address`. It latches the 20×64-bit instruction window into a local window buffer and carves variable-length instructions (1–16 bytes) out of that buffer, one per cycle, to the decode stage over a valid/ready handshake. It refills the window when too few bytes remain, restarts on a redirect, and halts on a zero opcode byte.

## Interface
Parameters:
- `RESET_PC`, 64'h0: fetch address loaded at reset.
- `WINDOW_WORDS`, 20: 64-bit words per window; must match `imemory` `data_out` depth (160 bytes).
- `MAX_LEN`, 16: maximum instruction length in bytes.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `address` out 64: byte address to `imemory`; equals registered `base`.
- `data_in` in 64 ×[19:0]: `imemory.data_out`; word i holds bytes `address+8i .. +8i+7`, little-endian.
- `redirect_valid` in 1: branch/jump restart request.
- `redirect_pc` in 64: restart byte address.
- `instr_valid` out 1: instruction presented.
- `instr_ready` in 1: decode accepts.
- `instr_data` out 128: instruction bytes; byte k at [8k+7:8k]; bytes ≥ `instr_len` are zero.
- `instr_len` out 5: length in bytes, 1..16.
- `instr_pc` out 64: byte address of the instruction.
- `halted` out 1: halt state indicator.

## Operation
- Length encoding: opcode byte b0 = window byte at `offset`. `len = b0[3:0] + 1`. `b0 == 8'h00` is HALT.
- Registers: `state`, `base` (64), `offset` (8, 0..159), `window` (160 bytes).
- State FILL:
  - `instr_valid = 0`.
  - At the clock edge: `window <= data_in`, `offset <= 0`, go to ISSUE.
- State ISSUE:
  - If `b0 == 0`: `instr_valid = 0`, go to HALTED.
  - Otherwise `instr_valid = 1`, `instr_pc = base + offset`.
  - On handshake (`instr_valid & instr_ready`): `next = offset + len`.
    - If `next > 160 - MAX_LEN` (i.e. > 144): `base <= base + next`, go to FILL.
    - Otherwise `offset <= next`.
  - Outputs are held stable while `instr_valid` is high and `instr_ready` is low.
- State HALTED:
  - `halted = 1`, `instr_valid = 0`.
  - Leaves only via redirect.
- Redirect (any state): `base <= redirect_pc`, go to FILL.
  - Redirect has priority over a same-cycle handshake. The handshaked instruction still counts as consumed by decode, but no advance is applied.
- Arithmetic: all address sums are 64-bit modulo 2^64 (wrap allowed). `offset + len` is computed in 9 bits.
- Addresses beyond memory: `imemory` returns zeros there, so fetch reaches HALTED naturally.
- Reset values:
  - state = FILL, `base` = RESET_PC, `offset` = 0, `window` = 0.
  - Outputs: `instr_valid` 0, `halted` 0, `address` RESET_PC.
  - `instr_data`, `instr_len`, `instr_pc` are don't-care while invalid but must be X-free.

## Timing
- Reset deassert → FILL for 1 cycle → first `instr_valid` on the 2nd cycle.
- Redirect sampled at edge E → FILL in cycle E+1 (`address = redirect_pc`) → `instr_valid` in cycle E+2.
- Steady state: one instruction per cycle while `instr_ready = 1`.
- Refill bubble: exactly 1 cycle (the FILL cycle) with `instr_valid = 0`.
- Output path: `instr_*` are combinational from registered `window`/`offset`/`base` only. There is no combinational path from `instr_ready` or `redirect_*` to any output.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight instruction is discarded.

## Structure
- Package `fetch_pkg`:
  - constants `WINDOW_BYTES = 160`, `MAX_INSTR_BYTES = 16`, `OP_HALT = 8'h00`
  - state enum {FILL, ISSUE, HALTED}
  - length-decode function `len_of(b0)`
- Sub-module `fetch_extract` (combinational): takes `window` + `offset`, produces the 16-byte slice with bytes ≥ `len` masked to zero, plus `instr_len`.
- `fetch_ctrl` holds the FSM, registers and handshake.

## Test plan
- Reset release with memory bytes 00-offset `11 22 33 44 05 …`, `instr_ready = 1`:
  - cycle 2: `instr_pc = 0`, `len = 2`, `instr_data = 16'h2211`.
  - next cycle: `instr_pc = 2`, `len = 4`.
- Backpressure: hold `instr_ready = 0` for 5 cycles on the `instr_pc = 2` instruction → outputs unchanged. Release → advances to `instr_pc = 6`.
- Refill boundary: a run of 16-byte instructions (b0 = 8'h0F) from 0 → after the accept at offset 144, `next = 160` → 1-cycle bubble, `address = 160`, next `instr_pc = 160`.
- Redirect during a stall with simultaneous `instr_ready = 1`, `redirect_pc = 64'h1000` → no advance. `instr_valid` drops for 1 cycle, then `instr_pc = 64'h1000`.
- Halt: b0 = 8'h00 at pc 8 → `instr_valid` stays 0, `halted = 1` from the next cycle and holds for 10 cycles. Redirect to 0 → `halted = 0`, instructions resume.
- Wrap and async reset: `redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8` with an 8-byte instruction → next `instr_pc = 0`. Then assert `reset` mid-cycle while valid → `instr_valid = 0` immediately, `address = RESET_PC`.
